// File: rtl/output_compositor_pkg.sv
// Shared types and VGA timing defaults for the output compositor.
// OUTPUT_COMPOSITOR_TESTPATTERN_EN adds the colour-bar test path.
package output_compositor_pkg;

  typedef logic [11:0] pixel_t;

  localparam int MESSAGE_SIZE = 32;

  localparam int VGA_CLK_DIV  = 4;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
`ifdef OUTPUT_COMPOSITOR_TESTPATTERN_EN
    logic [2:0] bar;
`endif
  } sync_t;

  localparam sync_t SYNC_IDLE =
    sync_t'({2'b11, {($bits(sync_t)-2){1'b0}}});

`ifdef OUTPUT_COMPOSITOR_TESTPATTERN_EN
  function automatic pixel_t bar_color(input logic [2:0] i);
    return {{4{i[2]}}, {4{i[1]}}, {4{i[0]}}};
  endfunction
`endif

endpackage

// File: rtl/output_compositor_timing.sv
// VGA timing generator: pixel-strobe divider, h/v counters,
// raw sync pulses and the active-region flag.
module vga_timing_gen
  import output_compositor_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       active
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_S0 = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_S1 = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_S0 = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_S1 = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);

  logic [DW-1:0] div_q, div_d;
  logic          pe_q, pe_d;
  logic [9:0]    h_q, h_d, v_q, v_d;

  // pix_en is registered so it is 0 straight out of reset
  always_comb begin
    div_d = (div_q == D_LAST) ? '0 : div_q + 1'b1;
    pe_d  = (div_d == D_LAST);
    h_d   = h_q;
    v_d   = v_q;
    if (pe_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q <= '0;
      pe_q  <= 1'b0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      pe_q  <= pe_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign pix_en    = pe_q;
  assign h_cnt     = h_q;
  assign v_cnt     = v_q;
  assign hsync_raw = !((h_q >= H_S0) && (h_q < H_S1));
  assign vsync_raw = !((v_q >= V_S0) && (v_q < V_S1));
  assign active    = (h_q < H_ACT) && (v_q < V_ACT);

endmodule

// File: rtl/output_compositor.sv
// VGA back-end: timing, layer compositor and per-frame datagram latch.
// OUTPUT_COMPOSITOR_TESTPATTERN_EN adds test_mode colour bars.
module output_compositor
  import output_compositor_pkg::*;
#(
  parameter int CLK_DIV       = VGA_CLK_DIV,
  parameter int H_ACTIVE      = VGA_H_ACTIVE,
  parameter int H_FP          = VGA_H_FP,
  parameter int H_SYNC        = VGA_H_SYNC,
  parameter int H_BP          = VGA_H_BP,
  parameter int V_ACTIVE      = VGA_V_ACTIVE,
  parameter int V_FP          = VGA_V_FP,
  parameter int V_SYNC        = VGA_V_SYNC,
  parameter int V_BP          = VGA_V_BP,
  parameter int NUM_LAYERS    = 4,
  parameter int LAYER_LATENCY = 1,
  parameter int DG_W          = MESSAGE_SIZE
) (
  input  logic                    clk,
`ifdef OUTPUT_COMPOSITOR_TESTPATTERN_EN
  input  logic                    test_mode,
`endif
  input  logic                    rst,
  input  logic [DG_W-1:0]         datagram,
  input  logic                    datagram_valid,
  output logic [DG_W-1:0]         frame_datagram,
  output logic                    frame_start,
  output logic [7:0]              dropped_cnt,
  output logic                    pix_en,
  output logic [9:0]              h_cnt,
  output logic [9:0]              v_cnt,
  input  logic [11:0]             bg_pixel,
  input  logic [NUM_LAYERS-1:0]   layer_valid,
  input  logic [12*NUM_LAYERS-1:0] layer_pixel,
  output logic [3:0]              vgaRed,
  output logic [3:0]              vgaGreen,
  output logic [3:0]              vgaBlue,
  output logic                    hsync,
  output logic                    vsync
);

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_CLAST = 10'(V_ACTIVE - 1);

  logic hsync_raw, vsync_raw, active;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
    .H_SYNC(H_SYNC), .H_BP(H_BP), .V_ACTIVE(V_ACTIVE),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .h_cnt(h_cnt), .v_cnt(v_cnt),
    .hsync_raw(hsync_raw), .vsync_raw(vsync_raw), .active(active)
  );

  sync_t raw_s, dly_s;

  always_comb begin
    raw_s     = SYNC_IDLE;
    raw_s.hs  = hsync_raw;
    raw_s.vs  = vsync_raw;
    raw_s.act = active;
`ifdef OUTPUT_COMPOSITOR_TESTPATTERN_EN
    raw_s.bar = h_cnt[9:7];
`endif
  end

  // Flags wait here until the layer pixels for the same coordinate arrive
  if (LAYER_LATENCY == 0) begin : g_nopipe
    assign dly_s = raw_s;
  end else begin : g_pipe
    sync_t pipe_q [LAYER_LATENCY];
    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int i = 0; i < LAYER_LATENCY; i++) pipe_q[i] <= SYNC_IDLE;
      end else if (pix_en) begin
        pipe_q[0] <= raw_s;
        for (int i = 1; i < LAYER_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign dly_s = pipe_q[LAYER_LATENCY-1];
  end

  pixel_t win, col_d, col_q;
  logic   hs_q, vs_q;

  always_comb begin
    win = bg_pixel;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (layer_valid[k]) win = layer_pixel[12*k +: 12];
    end
    col_d = dly_s.act ? win : 12'h000;
`ifdef OUTPUT_COMPOSITOR_TESTPATTERN_EN
    if (test_mode && dly_s.act) col_d = bar_color(dly_s.bar);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (pix_en) begin
      col_q <= col_d;
      hs_q  <= dly_s.hs;
      vs_q  <= dly_s.vs;
    end
  end

  assign {vgaRed, vgaGreen, vgaBlue} = col_q;
  assign hsync = hs_q;
  assign vsync = vs_q;

  logic            commit;
  logic [DG_W-1:0] pend_q, pend_d, fdg_q, fdg_d;
  logic            full_q, full_d, fs_q;
  logic [7:0]      drop_q, drop_d;

  assign commit = pix_en && (h_cnt == H_LAST) && (v_cnt == V_CLAST);

  // A datagram in the commit cycle bypasses pending entirely
  always_comb begin
    pend_d = pend_q;
    full_d = full_q;
    fdg_d  = fdg_q;
    drop_d = drop_q;
    if (datagram_valid && full_q && drop_q != 8'hFF) drop_d = drop_q + 1'b1;
    if (commit) begin
      full_d = 1'b0;
      if (datagram_valid) fdg_d = datagram;
      else if (full_q) fdg_d = pend_q;
    end else if (datagram_valid) begin
      pend_d = datagram;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= '0;
      full_q <= 1'b0;
      fdg_q  <= '0;
      drop_q <= '0;
      fs_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      full_q <= full_d;
      fdg_q  <= fdg_d;
      drop_q <= drop_d;
      fs_q   <= commit;
    end
  end

  assign frame_datagram = fdg_q;
  assign frame_start    = fs_q;
  assign dropped_cnt    = drop_q;

endmodule

// File: tb/tb_output_compositor.sv
// Randomized bench for output_compositor with a pixel-index reference model
// and directed literal checks on a shrunken display geometry.
module tb_output_compositor;

  localparam int CD = 3;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int NL = 4;
  localparam int LL = 1;
  localparam int DW = 32;

  logic clk = 0;
  logic rst = 0;
  logic [DW-1:0] datagram = 0;
  logic datagram_valid = 0;
  logic [11:0] bg_pixel = 0;
  logic [NL-1:0] layer_valid = 0;
  logic [12*NL-1:0] layer_pixel = 0;
`ifdef OUTPUT_COMPOSITOR_TESTPATTERN_EN
  logic test_mode = 0;
`endif

  logic [DW-1:0] frame_datagram;
  logic frame_start, pix_en, hsync, vsync;
  logic [7:0] dropped_cnt;
  logic [9:0] h_cnt, v_cnt;
  logic [3:0] vgaRed, vgaGreen, vgaBlue;

  output_compositor #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .NUM_LAYERS(NL), .LAYER_LATENCY(LL), .DG_W(DW)
  ) dut (
    .clk(clk),
`ifdef OUTPUT_COMPOSITOR_TESTPATTERN_EN
    .test_mode(test_mode),
`endif
    .rst(rst), .datagram(datagram), .datagram_valid(datagram_valid),
    .frame_datagram(frame_datagram), .frame_start(frame_start),
    .dropped_cnt(dropped_cnt), .pix_en(pix_en),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .bg_pixel(bg_pixel),
    .layer_valid(layer_valid), .layer_pixel(layer_pixel),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .hsync(hsync), .vsync(vsync)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  // Reference model: everything derives from cycles elapsed since reset.
  bit            mv = 0;
  int            cyc;
  logic [11:0]   m_col;
  logic          m_hs, m_vs, m_fs, m_full;
  logic [DW-1:0] m_fdg, m_pend;
  int            m_drop;

  function automatic logic [11:0] winner(input logic [NL-1:0] lv,
      input logic [12*NL-1:0] lp, input logic [11:0] bg);
    for (int k = 0; k < NL; k++) if (lv[k]) return lp[12*k +: 12];
    return bg;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        mv = 1; cyc = 0; m_col = 0; m_hs = 1; m_vs = 1; m_fs = 0;
        m_full = 0; m_fdg = 0; m_pend = 0; m_drop = 0;
      end else if (mv) begin
        int pc, hc, vc, q, hq, vq;
        bit pe, commit;
        pc = cyc / CD;
        pe = (cyc % CD) == CD - 1;
        hc = pc % HT;
        vc = (pc / HT) % VT;
        commit = pe && hc == HT - 1 && vc == VA - 1;
        m_fs = commit;
        if (datagram_valid && m_full && m_drop < 255) m_drop++;
        if (commit) begin
          if (datagram_valid) m_fdg = datagram;
          else if (m_full) m_fdg = m_pend;
          m_full = 0;
        end else if (datagram_valid) begin
          m_pend = datagram;
          m_full = 1;
        end
        if (pe) begin
          q = pc - LL;
          if (q < 0) begin
            m_col = 0; m_hs = 1; m_vs = 1;
          end else begin
            hq = q % HT;
            vq = (q / HT) % VT;
            m_col = (hq < HA && vq < VA) ?
                    winner(layer_valid, layer_pixel, bg_pixel) : 12'h000;
            m_hs = !(hq >= HA + HF && hq < HA + HF + HS);
            m_vs = !(vq >= VA + VF && vq < VA + VF + VS);
          end
        end
        cyc++;
      end
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      chk("pix_en", {31'd0, pix_en}, {31'd0, (cyc % CD) == CD - 1});
      chk("h_cnt", {22'd0, h_cnt}, (cyc / CD) % HT);
      chk("v_cnt", {22'd0, v_cnt}, (cyc / CD / HT) % VT);
      chk("colour", {20'd0, vgaRed, vgaGreen, vgaBlue}, {20'd0, m_col});
      chk("hsync", {31'd0, hsync}, {31'd0, m_hs});
      chk("vsync", {31'd0, vsync}, {31'd0, m_vs});
      chk("frame_start", {31'd0, frame_start}, {31'd0, m_fs});
      chk("frame_datagram", frame_datagram, m_fdg);
      chk("dropped_cnt", {24'd0, dropped_cnt}, m_drop);
    end
  end

  task automatic wait_hv(input int h, input int v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(h_cnt == h && v_cnt == v) && n < 4000);
    if (n >= 4000) timeout("wait_hv");
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 4000);
    if (n >= 4000) timeout("wait_frame_start");
  endtask

  initial begin
    int n;
    rst = 0;
    repeat (3) @(negedge clk);
    chk("rst_h", {22'd0, h_cnt}, 0);
    chk("rst_hsync", {31'd0, hsync}, 1);
    chk("rst_vsync", {31'd0, vsync}, 1);
    chk("rst_pix_en", {31'd0, pix_en}, 0);
    rst = 1;

    bg_pixel = 12'h00F;
    layer_pixel = {12'hABC, 12'h0F0, 12'hF00, 12'h123};
    layer_valid = 4'b0110;
    wait_hv(12, 1);
    chk("prio_layer1", {20'd0, vgaRed, vgaGreen, vgaBlue}, 32'hF00);
    layer_valid = 4'b0000;
    wait_hv(12, 2);
    chk("bg_only", {20'd0, vgaRed, vgaGreen, vgaBlue}, 32'h00F);
    layer_valid = 4'b1000;
    wait_hv(HA + 2, 2);
    chk("blank_black", {20'd0, vgaRed, vgaGreen, vgaBlue}, 32'h000);
    wait_hv(HA + HF + 1, 2);
    chk("hsync_before", {31'd0, hsync}, 1);
    wait_hv(HA + HF + 2, 2);
    chk("hsync_low", {31'd0, hsync}, 0);
    wait_hv(HA + HF + HS + 2, 2);
    chk("hsync_after", {31'd0, hsync}, 1);

    wait_hv(0, 3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(h_cnt == 0 && v_cnt == 4) && n < 1000);
    chk("line_period", n, HT * CD);

    wait_hv(0, 5);
    datagram = 32'hAAAA_0001; datagram_valid = 1;
    @(negedge clk);
    datagram_valid = 0;
    wait_hv(0, 6);
    datagram = 32'hBBBB_0002; datagram_valid = 1;
    @(negedge clk);
    datagram_valid = 0;
    wait_fs();
    chk("commit_B", frame_datagram, 32'hBBBB_0002);
    chk("commit_drop", {24'd0, dropped_cnt}, 1);
    chk("commit_v", {22'd0, v_cnt}, VA);
    chk("commit_h", {22'd0, h_cnt}, 0);
    @(negedge clk);
    chk("fs_one_clk", {31'd0, frame_start}, 0);

    wait_hv(2, VA + VF);
    chk("vsync_low", {31'd0, vsync}, 0);
    wait_hv(2, VA + VF + VS);
    chk("vsync_high", {31'd0, vsync}, 1);

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pix_en && h_cnt == HT - 1 && v_cnt == VA - 1) && n < 4000);
    if (n >= 4000) timeout("commit_cycle");
    datagram = 32'hCCCC_0003; datagram_valid = 1;
    @(negedge clk);
    datagram_valid = 0;
    chk("bypass_C", frame_datagram, 32'hCCCC_0003);
    chk("bypass_fs", {31'd0, frame_start}, 1);
    chk("bypass_drop", {24'd0, dropped_cnt}, 1);
    wait_fs();
    chk("hold_C", frame_datagram, 32'hCCCC_0003);

    wait_hv(5, 5);
    rst = 0;
    @(negedge clk);
    rst = 1;
    chk("mid_rst_h", {22'd0, h_cnt}, 0);
    chk("mid_rst_v", {22'd0, v_cnt}, 0);
    chk("mid_rst_col", {20'd0, vgaRed, vgaGreen, vgaBlue}, 0);
    chk("mid_rst_sync", {30'd0, hsync, vsync}, 3);
    chk("mid_rst_fdg", frame_datagram, 0);

    datagram_valid = 1;
    for (int i = 0; i < 300; i++) begin
      datagram = $urandom;
      @(negedge clk);
    end
    datagram_valid = 0;
    chk("drop_saturate", {24'd0, dropped_cnt}, 255);

    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      layer_valid = NL'($urandom);
      layer_pixel = {$urandom, $urandom};
      bg_pixel = 12'($urandom);
      datagram = $urandom;
      datagram_valid = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 4999) != 0);
    end
    rst = 1;
    datagram_valid = 0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
